pc_sequencer: RTL and testbench



---
 rtl/mips_pkg.sv | 31 +++
 rtl/next_pc_calc.sv | 65 ++++++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/execute sequencer and its decoder neighbours.
package mips_pkg;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StFetch = 2'd1,
      StExec  = 2'd2
   } seq_state_e;

   // Bit positions inside the {Z,N,V} status register.
   localparam int unsigned STAT_Z = 2;
   localparam int unsigned STAT_N = 1;
   localparam int unsigned STAT_V = 0;

   // Default destination for jalpc/baln/blezal link writes.
   localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;

   // Opcode constants shared with the main control decoder.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JALPC = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BLEZAL = 6'h07;
   localparam logic [5:0] OP_BALN  = 6'h1b;

   // Sign-extended word offset of a 16-bit branch immediate.
   function automatic logic [31:0] branch_off(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target select and link decision for one EXEC cycle.
module next_pc_calc
   import mips_pkg::*;
#(
   parameter logic [4:0] LINK_REG = LINK_REG_DEFAULT
) (
   input  logic [31:0] pc,
   input  logic [25:0] instr_idx,
   input  logic        status_n,
   input  logic        status_v,
   input  logic        branch,
   input  logic        brv,
   input  logic        jmxor,
   input  logic        jalpc,
   input  logic        baln,
   input  logic        blezal,
   input  logic        alu_zero,
   input  logic [31:0] rs_data,
   input  logic [31:0] dmem_rdata,
   input  logic [4:0]  rd_field,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        link_en,
   output logic [4:0]  link_reg
);

   logic [31:0] br_target;
   logic [31:0] target;
   logic        rs_le_zero;

   // Strobes are mutually exclusive; the if-chain order only fixes priority.
   always_comb begin
      pc_plus4   = pc + 32'd4;
      br_target  = pc_plus4 + branch_off(instr_idx[15:0]);
      rs_le_zero = rs_data[31] | (rs_data == 32'd0);
      target     = pc_plus4;
      link_en    = 1'b0;
      link_reg   = LINK_REG;
      if (jmxor) begin
         target   = dmem_rdata;
         link_en  = 1'b1;
         link_reg = rd_field;
      end else if (brv) begin
         if (status_v) target = rs_data;
      end else if (jalpc) begin
         target  = br_target;
         link_en = 1'b1;
      end else if (baln) begin
         if (status_n) begin
            target  = {pc_plus4[31:28], instr_idx, 2'b00};
            link_en = 1'b1;
         end
      end else if (blezal) begin
         if (rs_le_zero) begin
            target  = br_target;
            link_en = 1'b1;
         end
      end else if (branch) begin
         if (alu_zero) target = br_target;
      end
      // Register-sourced targets may be misaligned; force word alignment.
      next_pc = {target[31:2], 2'b00};
   end

endmodule

// File: rtl/pc_sequencer.sv
// PC / status owner that sequences FETCH and EXEC around a variable-latency imem.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [4:0]  LINK_REG = LINK_REG_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        exec_valid,
   output logic [31:0] pc,
   input  logic        branch,
   input  logic        brv,
   input  logic        jmxor,
   input  logic        jalpc,
   input  logic        baln,
   input  logic        blezal,
   input  logic        alu_zero,
   input  logic        alu_neg,
   input  logic        alu_ovf,
   input  logic        flag_we,
   input  logic [31:0] rs_data,
   input  logic [31:0] dmem_rdata,
   output logic [2:0]  status,
   output logic        link_en,
   output logic [4:0]  link_reg,
   output logic [31:0] link_data,
   input  logic [4:0]  rd_field
);

   seq_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  status_q, status_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic        link_take;

   next_pc_calc #(
      .LINK_REG (LINK_REG)
   ) u_next_pc_calc (
      .pc         (pc_q),
      .instr_idx  (instr_q[25:0]),
      .status_n   (status_q[STAT_N]),
      .status_v   (status_q[STAT_V]),
      .branch     (branch),
      .brv        (brv),
      .jmxor      (jmxor),
      .jalpc      (jalpc),
      .baln       (baln),
      .blezal     (blezal),
      .alu_zero   (alu_zero),
      .rs_data    (rs_data),
      .dmem_rdata (dmem_rdata),
      .rd_field   (rd_field),
      .pc_plus4   (pc_plus4),
      .next_pc    (next_pc),
      .link_en    (link_take),
      .link_reg   (link_reg)
   );

   // Next-state, register updates and handshake outputs.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      status_d = status_q;
      instr_d  = instr_q;
      unique case (state_q)
         StBoot:  state_d = StFetch;
         StFetch: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = StExec;
            end
         end
         StExec: begin
            // Branch conditions above used status_q, i.e. the pre-update flags.
            pc_d = next_pc;
            if (flag_we) begin
               status_d[STAT_Z] = alu_zero;
               status_d[STAT_N] = alu_neg;
               status_d[STAT_V] = alu_ovf;
            end
            state_d = StFetch;
         end
         default: state_d = StBoot;
      endcase
      imem_req   = (state_q == StFetch);
      exec_valid = (state_q == StExec);
      link_en    = exec_valid & link_take;
   end

   // State, PC, status and instruction latch; reset aborts any in-flight commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StBoot;
         pc_q     <= RESET_PC;
         status_q <= 3'b000;
         instr_q  <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         status_q <= status_d;
         instr_q  <= instr_d;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign status    = status_q;
   assign instr     = instr_q;
   assign link_data = pc_plus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        exec_valid;
   logic [31:0] pc;
   logic        branch, brv, jmxor, jalpc, baln, blezal;
   logic        alu_zero, alu_neg, alu_ovf, flag_we;
   logic [31:0] rs_data, dmem_rdata;
   logic [2:0]  status;
   logic        link_en;
   logic [4:0]  link_reg;
   logic [31:0] link_data;
   logic [4:0]  rd_field;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(
      .RESET_PC (32'h0000_0000),
      .LINK_REG (5'd31)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .exec_valid (exec_valid),
      .pc         (pc),
      .branch     (branch),
      .brv        (brv),
      .jmxor      (jmxor),
      .jalpc      (jalpc),
      .baln       (baln),
      .blezal     (blezal),
      .alu_zero   (alu_zero),
      .alu_neg    (alu_neg),
      .alu_ovf    (alu_ovf),
      .flag_we    (flag_we),
      .rs_data    (rs_data),
      .dmem_rdata (dmem_rdata),
      .status     (status),
      .link_en    (link_en),
      .link_reg   (link_reg),
      .link_data  (link_data),
      .rd_field   (rd_field)
   );

   always #5 clk = ~clk;

   task automatic clear_ctl();
      branch = 0; brv = 0; jmxor = 0; jalpc = 0; baln = 0; blezal = 0;
      alu_zero = 0; alu_neg = 0; alu_ovf = 0; flag_we = 0;
      rs_data = '0; dmem_rdata = '0; rd_field = '0;
   endtask

   // Wait (bounded) for FETCH, deliver one instruction, return in its EXEC cycle.
   task automatic issue(input logic [31:0] ins, output bit ok);
      for (int k = 0; k < 8 && !imem_req; k++) @(negedge clk);
      imem_rdata = ins;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      ok = exec_valid;
   endtask

   // Run one instruction with the current controls; report what EXEC showed.
   task automatic run_op(input logic [31:0] ins, output bit ok, output logic le,
                         output logic [4:0] lr, output logic [31:0] ld,
                         output logic [31:0] np);
      issue(ins, ok);
      le = link_en;
      lr = link_reg;
      ld = link_data;
      @(negedge clk);
      np = pc;
      clear_ctl();
   endtask

   bit          ok;
   logic        le;
   logic [4:0]  lr;
   logic [31:0] ld, np;

   task automatic test_reset();
      reset_n = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = '0;
      clear_ctl();
      repeat (2) @(negedge clk);
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      checks++; if (imem_req !== 1'b0 || exec_valid !== 1'b0 || link_en !== 1'b0) begin
         errors++; $display("FAIL reset_ctl got req=%b ev=%b le=%b want 0 0 0", imem_req, exec_valid, link_en);
      end
      checks++; if (status !== 3'b000 || instr !== 32'h0) begin
         errors++; $display("FAIL reset_regs got status=%b instr=%h want 000 0", status, instr);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_nop_stream();
      imem_ack = 1'b1;
      imem_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 8 && !imem_req; k++) @(negedge clk);
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
            errors++; $display("FAIL nop_fetch%0d got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, 32'(i * 4));
         end
         @(negedge clk);
         checks++; if (exec_valid !== 1'b1 || pc !== 32'(i * 4)) begin
            errors++; $display("FAIL nop_exec%0d got ev=%b pc=%h want 1 %h", i, exec_valid, pc, 32'(i * 4));
         end
         @(negedge clk);
         checks++; if (exec_valid !== 1'b0) begin
            errors++; $display("FAIL nop_gap%0d got ev=%b want 0", i, exec_valid);
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_ack_delay();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (imem_req !== 1'b1 || pc !== 32'h10 || exec_valid !== 1'b0) begin
            errors++; $display("FAIL delay_hold%0d got req=%b pc=%h ev=%b want 1 10 0", i, imem_req, pc, exec_valid);
         end
      end
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (exec_valid !== 1'b1) begin errors++; $display("FAIL delay_exec got ev=%b want 1", exec_valid); end
      @(negedge clk);
      checks++; if (pc !== 32'h14 || exec_valid !== 1'b0) begin
         errors++; $display("FAIL delay_next got pc=%h ev=%b want 14 0", pc, exec_valid);
      end
   endtask

   task automatic test_beq();
      jmxor = 1; dmem_rdata = 32'h20;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (!ok || np !== 32'h20) begin errors++; $display("FAIL beq_setup got ok=%b pc=%h want 1 20", ok, np); end
      branch = 1; alu_zero = 1;
      run_op(32'h1000_FFFF, ok, le, lr, ld, np);
      checks++; if (!ok || np !== 32'h20) begin errors++; $display("FAIL beq_taken got ok=%b pc=%h want 1 20", ok, np); end
      branch = 1; alu_zero = 0;
      run_op(32'h1000_FFFF, ok, le, lr, ld, np);
      checks++; if (np !== 32'h24) begin errors++; $display("FAIL beq_not_taken got pc=%h want 24", np); end
   endtask

   task automatic test_brv();
      flag_we = 1; alu_ovf = 1;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (status !== 3'b001 || np !== 32'h28) begin
         errors++; $display("FAIL brv_setflag got status=%b pc=%h want 001 28", status, np);
      end
      // Same-cycle flag clear must not affect this brv.
      brv = 1; rs_data = 32'h400; flag_we = 1;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (np !== 32'h400 || status !== 3'b000) begin
         errors++; $display("FAIL brv_taken got pc=%h status=%b want 400 000", np, status);
      end
      brv = 1; rs_data = 32'h800;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (np !== 32'h404) begin errors++; $display("FAIL brv_not_taken got pc=%h want 404", np); end
   endtask

   task automatic test_baln();
      flag_we = 1; alu_neg = 1;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (status !== 3'b010) begin errors++; $display("FAIL baln_setflag got status=%b want 010", status); end
      jmxor = 1; dmem_rdata = 32'h1000;
      run_op(32'h0, ok, le, lr, ld, np);
      baln = 1;
      run_op(32'h6C00_0040, ok, le, lr, ld, np);
      checks++; if (np !== 32'h100 || le !== 1'b1 || lr !== 5'd31 || ld !== 32'h1004) begin
         errors++; $display("FAIL baln_taken got pc=%h le=%b lr=%0d ld=%h want 100 1 31 1004", np, le, lr, ld);
      end
      flag_we = 1;
      run_op(32'h0, ok, le, lr, ld, np);
      baln = 1;
      run_op(32'h6C00_0040, ok, le, lr, ld, np);
      checks++; if (np !== 32'h108 || le !== 1'b0) begin
         errors++; $display("FAIL baln_not_taken got pc=%h le=%b want 108 0", np, le);
      end
   endtask

   task automatic test_blezal();
      blezal = 1; rs_data = 32'h8000_0000;
      run_op(32'h1C00_0010, ok, le, lr, ld, np);
      checks++; if (np !== 32'h14C || le !== 1'b1 || lr !== 5'd31 || ld !== 32'h10C) begin
         errors++; $display("FAIL blezal_neg got pc=%h le=%b lr=%0d ld=%h want 14c 1 31 10c", np, le, lr, ld);
      end
      blezal = 1; rs_data = 32'h0;
      run_op(32'h1C00_0010, ok, le, lr, ld, np);
      checks++; if (np !== 32'h190 || le !== 1'b1) begin
         errors++; $display("FAIL blezal_zero got pc=%h le=%b want 190 1", np, le);
      end
      blezal = 1; rs_data = 32'h1;
      run_op(32'h1C00_0010, ok, le, lr, ld, np);
      checks++; if (np !== 32'h194 || le !== 1'b0) begin
         errors++; $display("FAIL blezal_pos got pc=%h le=%b want 194 0", np, le);
      end
   endtask

   task automatic test_jalpc();
      jalpc = 1;
      run_op(32'h0C00_FFFE, ok, le, lr, ld, np);
      checks++; if (np !== 32'h190 || le !== 1'b1 || lr !== 5'd31 || ld !== 32'h198) begin
         errors++; $display("FAIL jalpc got pc=%h le=%b lr=%0d ld=%h want 190 1 31 198", np, le, lr, ld);
      end
   endtask

   task automatic test_jmxor();
      jmxor = 1; dmem_rdata = 32'h2000; rd_field = 5'd5;
      checks++; if (link_en !== 1'b0) begin errors++; $display("FAIL link_gated got le=%b want 0", link_en); end
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (np !== 32'h2000 || le !== 1'b1 || lr !== 5'd5 || ld !== 32'h194) begin
         errors++; $display("FAIL jmxor got pc=%h le=%b lr=%0d ld=%h want 2000 1 5 194", np, le, lr, ld);
      end
      jmxor = 1; dmem_rdata = 32'h3003;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (np !== 32'h3000) begin errors++; $display("FAIL align got pc=%h want 3000", np); end
      jmxor = 1; dmem_rdata = 32'hFFFF_FFFC;
      run_op(32'h0, ok, le, lr, ld, np);
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (np !== 32'h0) begin errors++; $display("FAIL wrap got pc=%h want 0", np); end
   endtask

   task automatic test_reset_mid_exec();
      flag_we = 1; alu_ovf = 1;
      run_op(32'h0, ok, le, lr, ld, np);
      jmxor = 1; dmem_rdata = 32'h500; flag_we = 1; alu_neg = 1;
      issue(32'h1234_5678, ok);
      checks++; if (!ok || pc !== 32'h4 || status !== 3'b001) begin
         errors++; $display("FAIL rst_pre got ok=%b pc=%h status=%b want 1 4 001", ok, pc, status);
      end
      reset_n = 1'b0;
      #1;
      checks++; if (pc !== 32'h0 || status !== 3'b000 || exec_valid !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL rst_abort got pc=%h status=%b ev=%b req=%b want 0 000 0 0", pc, status, exec_valid, imem_req);
      end
      checks++; if (instr !== 32'h0 || link_en !== 1'b0) begin
         errors++; $display("FAIL rst_abort_out got instr=%h le=%b want 0 0", instr, link_en);
      end
      clear_ctl();
      @(negedge clk);
      reset_n = 1'b1;
      run_op(32'h0, ok, le, lr, ld, np);
      checks++; if (!ok || np !== 32'h4) begin errors++; $display("FAIL rst_resume got ok=%b pc=%h want 1 4", ok, np); end
   endtask

   initial begin
      test_reset();
      test_nop_stream();
      test_ack_delay();
      test_beq();
      test_brv();
      test_baln();
      test_blezal();
      test_jalpc();
      test_jmxor();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case a wait ever misbehaves.
   initial begin
      #200000;
      $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
